// File: rtl/spi_cfg_pkg.sv
// Shared constants, register map and FSM state type for the SPI configuration master.
package spi_cfg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam logic        WRITE_BIT  = 1'b1;
    localparam logic [6:0]  MAX_ADDR   = 7'd4;

    localparam logic [6:0] OUT_7_0  = 7'd0;
    localparam logic [6:0] OUT_15_8 = 7'd1;
    localparam logic [6:0] PWM_7_0  = 7'd2;
    localparam logic [6:0] PWM_15_8 = 7'd3;
    localparam logic [6:0] DUTY     = 7'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSclkHi,
        StSclkLo,
        StHold,
        StGap
    } state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] addr,
                                                          input logic [7:0] data);
        return {WRITE_BIT, addr, data};
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, priority pointer moves on each advance strobe.
module spi_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    // Set when requester 1 wins a tie.
    logic r_prio;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_prio ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_advance && (o_gnt != 2'b00)) begin
            r_prio <= o_gnt[0];
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 write-only master serialising 16-bit register writes from two requesters.
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic [6:0] i_req_addr0,
    input  logic [6:0] i_req_addr1,
    input  logic [7:0] i_req_data0,
    input  logic [7:0] i_req_data1,
    output logic [1:0] o_gnt,
    output logic       o_err,
    output logic       o_done,
    output logic       o_done_id,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_ncs,
    output logic       o_copi
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    state_e r_state, w_state_nx;
    logic [7:0]            r_cnt, w_cnt_nx;
    logic [3:0]            r_bit, w_bit_nx;
    logic [FRAME_BITS-2:0] r_shift, w_shift_nx;
    logic                  r_sclk, w_sclk_nx;
    logic                  r_ncs, w_ncs_nx;
    logic                  r_copi, w_copi_nx;
    logic                  r_done, w_done_nx;
    logic                  r_done_id, w_done_id_nx;
    logic                  r_id, w_id_nx;
    logic                  r_run;

    logic [1:0]            w_arb_gnt;
    logic                  w_take;
    logic                  w_sel_id;
    logic [6:0]            w_sel_addr;
    logic [7:0]            w_sel_data;
    logic                  w_addr_bad;
    logic                  w_cnt_last;
    logic [FRAME_BITS-1:0] w_frame;

    // r_run keeps requests from being granted while reset is still asserted.
    assign w_take     = r_run && (r_state == StIdle) && (i_req != 2'b00);
    assign w_sel_id   = w_arb_gnt[1];
    assign w_sel_addr = w_sel_id ? i_req_addr1 : i_req_addr0;
    assign w_sel_data = w_sel_id ? i_req_data1 : i_req_data0;
    assign w_addr_bad = (w_sel_addr > MAX_ADDR);
    assign w_frame    = build_frame(w_sel_addr, w_sel_data);
    assign w_cnt_last = (r_cnt == DIV_LAST);

    spi_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_advance (w_take),
        .o_gnt     (w_arb_gnt)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_bit_nx     = r_bit;
        w_shift_nx   = r_shift;
        w_sclk_nx    = r_sclk;
        w_ncs_nx     = r_ncs;
        w_copi_nx    = r_copi;
        w_done_nx    = 1'b0;
        w_done_id_nx = r_done_id;
        w_id_nx      = r_id;

        unique case (r_state)
            StIdle: begin
                if (w_take && !w_addr_bad) begin
                    w_state_nx = StSetup;
                    w_cnt_nx   = 8'd0;
                    w_bit_nx   = 4'd0;
                    w_shift_nx = w_frame[FRAME_BITS-2:0];
                    w_copi_nx  = w_frame[FRAME_BITS-1];
                    w_ncs_nx   = 1'b0;
                    w_sclk_nx  = 1'b0;
                    w_id_nx    = w_sel_id;
                end
            end
            StSetup, StSclkLo: begin
                if (w_cnt_last) begin
                    w_state_nx = StSclkHi;
                    w_cnt_nx   = 8'd0;
                    w_sclk_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            StSclkHi: begin
                if (w_cnt_last) begin
                    w_cnt_nx  = 8'd0;
                    w_sclk_nx = 1'b0;
                    w_bit_nx  = r_bit + 4'd1;
                    if (r_bit == BIT_LAST) begin
                        w_state_nx = StHold;
                    end else begin
                        // Falling edge: present the next bit.
                        w_state_nx = StSclkLo;
                        w_copi_nx  = r_shift[FRAME_BITS-2];
                        w_shift_nx = {r_shift[FRAME_BITS-3:0], 1'b0};
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            StHold: begin
                if (w_cnt_last) begin
                    w_state_nx   = StGap;
                    w_cnt_nx     = 8'd0;
                    w_ncs_nx     = 1'b1;
                    w_copi_nx    = 1'b0;
                    w_done_nx    = 1'b1;
                    w_done_id_nx = r_id;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            StGap: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nx = StIdle;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = StIdle;
                w_cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= 8'd0;
            r_bit     <= 4'd0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_ncs     <= 1'b1;
            r_copi    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_id      <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit     <= w_bit_nx;
            r_shift   <= w_shift_nx;
            r_sclk    <= w_sclk_nx;
            r_ncs     <= w_ncs_nx;
            r_copi    <= w_copi_nx;
            r_done    <= w_done_nx;
            r_done_id <= w_done_id_nx;
            r_id      <= w_id_nx;
            r_run     <= 1'b1;
        end
    end

    assign o_gnt     = w_take ? w_arb_gnt : 2'b00;
    assign o_err     = w_take && w_addr_bad;
    assign o_done    = r_done;
    assign o_done_id = r_done_id;
    assign o_busy    = (r_state != StIdle);
    assign o_sclk    = r_sclk;
    assign o_ncs     = r_ncs;
    assign o_copi    = r_copi;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with a register-file peripheral model on the SPI bus.
module tb_spi_cfg_master;
    import spi_cfg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [6:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic [1:0] o_gnt;
    logic       o_err, o_done, o_done_id, o_busy, o_sclk, o_ncs, o_copi;

    always #5 clk = ~clk;

    spi_cfg_master #(.CLK_DIV(4), .GAP_CYC(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_req_addr0 (addr0),
        .i_req_addr1 (addr1),
        .i_req_data0 (data0),
        .i_req_data1 (data1),
        .o_gnt       (o_gnt),
        .o_err       (o_err),
        .o_done      (o_done),
        .o_done_id   (o_done_id),
        .o_busy      (o_busy),
        .o_sclk      (o_sclk),
        .o_ncs       (o_ncs),
        .o_copi      (o_copi)
    );

    int checks = 0;
    int errors = 0;

    // Peripheral: shifts copi on sclk rise, commits only complete 16-edge write frames.
    logic [7:0]  p_regs [5] = '{default: 8'h00};
    logic [15:0] p_sh = 16'h0000;
    logic [15:0] p_last_frame = 16'h0000;
    int          p_edges = 0;
    int          p_last_edges = 0;

    always @(posedge o_sclk) begin
        if (o_ncs === 1'b0) begin
            p_sh = {p_sh[14:0], o_copi};
            p_edges++;
        end
    end

    always @(negedge o_ncs) p_edges = 0;

    always @(posedge o_ncs) begin
        p_last_frame = p_sh;
        p_last_edges = p_edges;
        if (p_edges == 16 && p_sh[15] && p_sh[14:8] <= 7'd4) p_regs[int'(p_sh[14:8])] = p_sh[7:0];
    end

    // Bus timing and pulse-width monitor.
    int         low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    int         done_cnt = 0, viol = 0;
    logic       prev_ncs = 1'b1, prev_err = 1'b0, prev_done = 1'b0;
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge clk) begin
        if (o_ncs === 1'b0) begin
            if (prev_ncs) begin
                last_high = high_run;
                low_run   = 1;
            end else begin
                low_run++;
            end
        end else begin
            if (!prev_ncs) begin
                last_low = low_run;
                high_run = 1;
            end else begin
                high_run++;
            end
        end
        prev_ncs = (o_ncs !== 1'b0);
        if (o_gnt == 2'b11) viol++;
        if (o_gnt != 2'b00 && prev_gnt != 2'b00) viol++;
        if (o_err && prev_err) viol++;
        if (o_done && prev_done) viol++;
        if (o_done === 1'b1) done_cnt++;
        prev_gnt  = o_gnt;
        prev_err  = o_err;
        prev_done = o_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic [1:0] g, output logic e);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (o_gnt != 2'b00) break;
        end
        chk("gnt_seen", {31'd0, (o_gnt != 2'b00)}, 32'd1);
        g = o_gnt;
        e = o_err;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (o_done === 1'b1) break;
        end
        chk("done_seen", {31'd0, o_done}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (o_busy === 1'b0) break;
        end
        chk("idle_seen", {31'd0, o_busy}, 32'd0);
    endtask

    logic [1:0] g;
    logic       e;

    initial begin
        // Reset with both requests already pending.
        rst_n = 1'b0;
        req   = 2'b11;
        addr0 = OUT_7_0;  data0 = 8'hFF;
        addr1 = OUT_15_8; data1 = 8'h0F;
        repeat (3) @(negedge clk);
        chk("rst_ncs", o_ncs, 1);
        chk("rst_sclk", o_sclk, 0);
        chk("rst_copi", o_copi, 0);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_err", o_err, 0);
        chk("rst_done", o_done, 0);
        chk("rst_done_id", o_done_id, 0);
        chk("rst_busy", o_busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Simultaneous requests: requester 0 first, requester 1 after the gap.
        wait_gnt(g, e);
        chk("a_gnt0", g, 2'b01);
        chk("a_err0", e, 0);
        @(posedge clk); #1 req = 2'b10;
        @(negedge clk);
        chk("a_ncs_low", o_ncs, 0);
        chk("a_copi_b15", o_copi, 1);
        chk("a_sclk_low", o_sclk, 0);
        chk("a_gnt_pulse", o_gnt, 0);
        chk("a_busy", o_busy, 1);
        wait_done();
        chk("a_done_id0", o_done_id, 0);
        @(negedge clk);
        chk("a_frame0", p_last_frame, 16'h80FF);
        chk("a_edges0", p_last_edges, 16);
        chk("a_low0", last_low, 132);
        wait_gnt(g, e);
        chk("a_gnt1", g, 2'b10);
        chk("a_err1", e, 0);
        @(posedge clk); #1 req = 2'b00;
        wait_done();
        chk("a_done_id1", o_done_id, 1);
        @(negedge clk);
        chk("a_frame1", p_last_frame, 16'h810F);
        chk("a_gap", last_high, 9);
        chk("a_out_7_0", p_regs[0], 8'hFF);
        chk("a_out_15_8", p_regs[1], 8'h0F);

        // Single write to DUTY.
        wait_idle();
        @(posedge clk); #1 req = 2'b01; addr0 = DUTY; data0 = 8'hA5;
        wait_gnt(g, e);
        chk("b_gnt", g, 2'b01);
        chk("b_err", e, 0);
        @(posedge clk); #1 req = 2'b00;
        wait_done();
        chk("b_done_id", o_done_id, 0);
        @(negedge clk);
        chk("b_frame", p_last_frame, 16'h84A5);
        chk("b_edges", p_last_edges, 16);
        chk("b_low", last_low, 132);
        chk("b_duty", p_regs[4], 8'hA5);

        // Out-of-range address is rejected without a frame.
        wait_idle();
        @(posedge clk); #1 req = 2'b10; addr1 = 7'd5; data1 = 8'h33;
        wait_gnt(g, e);
        chk("c_gnt", g, 2'b10);
        chk("c_err", e, 1);
        @(posedge clk); #1 req = 2'b00;
        @(negedge clk);
        chk("c_ncs_high", o_ncs, 1);
        chk("c_busy", o_busy, 0);
        chk("c_err_pulse", o_err, 0);
        @(posedge clk); #1 req = 2'b01; addr0 = PWM_7_0; data0 = 8'h5A;
        @(negedge clk);
        chk("c_next_gnt", o_gnt, 2'b01);
        chk("c_next_err", o_err, 0);
        @(posedge clk); #1 req = 2'b00;
        wait_done();
        @(negedge clk);
        chk("c_pwm_7_0", p_regs[2], 8'h5A);
        chk("c_done_cnt", done_cnt, 4);

        // Reset mid-frame after the 6th rising edge.
        wait_idle();
        @(posedge clk); #1 req = 2'b01; addr0 = PWM_15_8; data0 = 8'hC3;
        wait_gnt(g, e);
        chk("d_gnt", g, 2'b01);
        @(posedge clk); #1 req = 2'b00;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (p_edges == 6) break;
        end
        chk("d_edges6", p_edges, 6);
        rst_n = 1'b0;
        #1;
        chk("d_ncs_async", o_ncs, 1);
        chk("d_sclk_async", o_sclk, 0);
        chk("d_done", o_done, 0);
        chk("d_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("d_pwm_15_8", p_regs[3], 8'h00);
        chk("d_last_edges", p_last_edges, 6);
        chk("d_done_cnt", done_cnt, 4);

        // Both requests held: grants alternate.
        @(posedge clk); #1;
        req = 2'b11;
        addr0 = OUT_7_0;  data0 = 8'h3C;
        addr1 = OUT_15_8; data1 = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, e);
            chk("e_gnt", g, (i % 2 == 1) ? 2'b10 : 2'b01);
            chk("e_err", e, 0);
            if (i == 3) begin
                @(posedge clk); #1 req = 2'b00;
            end
            wait_done();
            chk("e_done_id", o_done_id, i % 2);
            @(negedge clk);
            chk("e_low", last_low, 132);
            if (i > 0) chk("e_gap", last_high, 9);
        end
        wait_idle();
        chk("e_out_7_0", p_regs[0], 8'h3C);
        chk("e_out_15_8", p_regs[1], 8'hC3);
        chk("e_done_cnt", done_cnt, 8);
        chk("pulse_rules", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
